instr_sequencer: RTL and testbench

//  Multi-cycle fetch/execute controller for the 9-bit ISA.
//  - Owns the PC and the instruction register; drives instruction-ROM addressing.
//  - Consumes the control decoder's flags, gates register-file and put-register writes, and runs data-memory handshakes.
//  - Resolves jump and branch targets, and detects halt.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_mem_timer.sv | 40 ++++
 rtl/instr_sequencer.sv | 174 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the 9-bit ISA fetch/execute sequencer.
// SEQ_SINGLE_STEP_EN adds the STEP_WAIT state to the state enum.
package seq_pkg;

    localparam int unsigned SEQ_PC_W = 10;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JUMP = 4'h8;

    localparam logic [3:0] ALU_BEQ = 4'h9;
    localparam logic [3:0] ALU_BLT = 4'h7;
    localparam logic [3:0] ALU_BGT = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_HALT
`ifdef SEQ_SINGLE_STEP_EN
        , ST_STEP_WAIT
`endif
    } seq_state_e;

    function automatic logic is_branch_alu(input logic [3:0] op);
        return (op == ALU_BEQ) || (op == ALU_BLT) || (op == ALU_BGT);
    endfunction

endpackage

// File: rtl/seq_mem_timer.sv
// Data-memory wait timer: cleared on request issue, counts MEM_WAIT cycles,
// saturates at MEM_TO and flags expiry.
module seq_mem_timer #(
    parameter int unsigned MEM_TO = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(MEM_TO + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        expired_d = (cnt_d == CNT_W'(MEM_TO));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute controller for the 9-bit ISA: PC, IR, retire and
// branch resolution, data-memory handshake. Optional macro: SEQ_SINGLE_STEP_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W     = SEQ_PC_W,
    parameter int unsigned PROG_LEN = 1024,
    parameter int unsigned MEM_TO   = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic            branch_flag,
    input  logic            mem_to_reg,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic            put_en,
    input  logic [3:0]      alu_op,
    input  logic [7:0]      value,
    input  logic            alu_cond,
    input  logic            dmem_ack,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] pc,
    output logic [8:0]      ir_q,
    output logic            rf_we,
    output logic            put_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            busy,
    output logic            done,
    output logic            mem_err,
    output logic [15:0]     retired
);

`ifdef SEQ_SINGLE_STEP_EN
    localparam seq_state_e ST_RESUME = ST_STEP_WAIT;
`else
    localparam seq_state_e ST_RESUME = ST_FETCH;
`endif

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [8:0]       ir_d;
    logic [7:0]       target_q, target_d;
    logic [15:0]      retired_q, retired_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mem_err_q, mem_err_d;
    logic             do_retire;
    logic             timer_expired;

    logic is_halt, is_mem, exec_live, taken, last_pc;

    assign is_halt   = !ir_q[0] && (ir_q[4:1] == OP_HALT);
    assign is_mem    = mem_to_reg || mem_write;
    assign exec_live = (state_q == ST_EXEC) && !is_halt;
    assign taken     = branch_flag || (is_branch_alu(alu_op) && alu_cond);
    assign last_pc   = (pc_q == PC_W'(PROG_LEN - 1));

    // Strobes decoded from state and the latched instruction's flags
    assign put_we   = exec_live && put_en;
    assign rf_we    = (exec_live && !put_en && !is_mem && reg_write)
                   || ((state_q == ST_MEM_WAIT) && dmem_ack && mem_to_reg);
    assign dmem_req = (exec_live && !put_en && is_mem) || (state_q == ST_MEM_WAIT);
    assign dmem_we  = dmem_req && mem_write;

    seq_mem_timer #(.MEM_TO(MEM_TO)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q == ST_EXEC),
        .en      (state_q == ST_MEM_WAIT),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        target_d  = target_q;
        retired_d = retired_q;
        mem_err_d = mem_err_q;
        do_retire = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    mem_err_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (put_en) begin
                    target_d  = value;
                    do_retire = 1'b1;
                end else if (is_mem) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    do_retire = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    do_retire = 1'b1;
                end else if (timer_expired) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (step) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Retire: count, then resolve the next PC (taken target uses pre-put target_q)
        if (do_retire) begin
            if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
            if (taken) begin
                pc_d    = PC_W'(target_q);
                state_d = ST_RESUME;
            end else if (last_pc) begin
                state_d = ST_HALT;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_RESUME;
            end
        end

        busy_d = !((state_d == ST_IDLE) || (state_d == ST_HALT));
        done_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            target_q  <= '0;
            retired_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            target_q  <= target_d;
            retired_q <= retired_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed ROM programs, expected
// strobe/halt events queued by stimulus and checked by a negedge monitor.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int unsigned PC_W     = 10;
    localparam int unsigned PROG_LEN = 64;
    localparam int unsigned MEM_TO   = 4;

    localparam int EV_PUT  = 1;
    localparam int EV_RF   = 2;
    localparam int EV_HALT = 3;

    localparam logic [8:0] I_NOP   = 9'h000;
    localparam logic [8:0] I_ADD   = 9'h002;
    localparam logic [8:0] I_LOAD  = 9'h004;
    localparam logic [8:0] I_STORE = 9'h006;
    localparam logic [8:0] I_JUMP  = 9'h010;
    localparam logic [8:0] I_BEQ   = 9'h012;
    localparam logic [8:0] I_HALT  = 9'h01E;

    typedef struct {
        int          kind;
        logic [9:0]  pc;
        logic [15:0] retired;
        logic        merr;
    } exp_t;

    logic            clk, reset, start;
    logic [8:0]      instr;
    logic            branch_flag, mem_to_reg, mem_write, reg_write, put_en;
    logic [3:0]      alu_op;
    logic [7:0]      value;
    logic            alu_cond, dmem_ack;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir_q;
    logic            rf_we, put_we, dmem_req, dmem_we, busy, done, mem_err;
    logic [15:0]     retired;
`ifdef SEQ_SINGLE_STEP_EN
    logic            step;
    assign step = 1'b1;
`endif

    logic [8:0] rom [0:1023];
    exp_t       sbq[$];
    int         n_checks = 0;
    int         n_errors = 0;

    assign instr = rom[pc];

    instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .MEM_TO(MEM_TO)) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .branch_flag(branch_flag), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .reg_write(reg_write), .put_en(put_en), .alu_op(alu_op), .value(value),
        .alu_cond(alu_cond), .dmem_ack(dmem_ack),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .pc(pc), .ir_q(ir_q), .rf_we(rf_we), .put_we(put_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .busy(busy), .done(done), .mem_err(mem_err), .retired(retired)
    );

    // Reference decoder for the bench's encoding: {hi[3:0], op[3:0], put}
    always_comb begin
        branch_flag = 1'b0;
        mem_to_reg  = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        put_en      = 1'b0;
        alu_op      = 4'h0;
        value       = ir_q[8:1];
        if (ir_q[0]) begin
            put_en = 1'b1;
        end else begin
            case (ir_q[4:1])
                OP_JUMP: branch_flag = 1'b1;
                4'h1:    reg_write   = 1'b1;
                4'h2:    mem_to_reg  = 1'b1;
                4'h3:    mem_write   = 1'b1;
                4'h9:    alu_op      = ALU_BEQ;
                default: ;
            endcase
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [9:0] epc,
                        input logic [15:0] eret, input logic emerr);
        exp_t e;
        e.kind = kind; e.pc = epc; e.retired = eret; e.merr = emerr;
        sbq.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: event %0d at pc 0x%0h, expected no event", kind, pc);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            chk("sb_pc", 32'(pc), 32'(e.pc));
            if (kind == EV_HALT) begin
                chk("sb_retired", 32'(retired), 32'(e.retired));
                chk("sb_mem_err", 32'(mem_err), 32'(e.merr));
            end
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a strobe or enters HALT
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (put_we) check_ev(EV_PUT);
                if (rf_we)  check_ev(EV_RF);
                if (done && !done_prev) check_ev(EV_HALT);
            end
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && !done; i++) tick();
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !dmem_req; i++) tick();
        chk(name, 32'(dmem_req), 32'd1);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; alu_cond = 1'b0; dmem_ack = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir_q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_strobes", 32'({rf_we, put_we, dmem_req, dmem_we}), 32'd0);

        // T1: put 5; add; halt with strobe timing relative to start
        rom[0] = 9'h00B; rom[1] = I_ADD; rom[2] = I_HALT;
        push(EV_PUT, 10'd0, 16'd0, 1'b0);
        push(EV_RF, 10'd1, 16'd0, 1'b0);
        push(EV_HALT, 10'd2, 16'd2, 1'b0);
        start_run();
        chk("t1_busy_fetch", 32'(busy), 32'd1);
        tick(); chk("t1_put_we_c2", 32'(put_we), 32'd1);
        tick(); chk("t1_rf_we_c3", 32'(rf_we), 32'd0);
        tick(); chk("t1_rf_we_c4", 32'(rf_we), 32'd1);
        wait_done("t1_done");
        chk("t1_busy_end", 32'(busy), 32'd0);

        // T2: put 0x20; jump -> target
        clear_rom();
        rom[0] = 9'h041; rom[1] = I_JUMP; rom[32] = I_HALT;
        push(EV_PUT, 10'd0, 16'd0, 1'b0);
        push(EV_HALT, 10'h20, 16'd2, 1'b0);
        start_run();
        wait_done("t2_jump_done");

        // T2b: beq not taken falls through to pc 2
        rom[1] = I_BEQ; rom[2] = I_HALT; alu_cond = 1'b0;
        push(EV_PUT, 10'd0, 16'd0, 1'b0);
        push(EV_HALT, 10'd2, 16'd2, 1'b0);
        start_run();
        wait_done("t2_beq_nt_done");

        // T2c: beq taken
        alu_cond = 1'b1;
        push(EV_PUT, 10'd0, 16'd0, 1'b0);
        push(EV_HALT, 10'h20, 16'd2, 1'b0);
        start_run();
        wait_done("t2_beq_t_done");
        alu_cond = 1'b0;

        // T3: load acked in the third MEM_WAIT cycle
        clear_rom();
        rom[0] = I_LOAD; rom[1] = I_HALT;
        push(EV_RF, 10'd0, 16'd0, 1'b0);
        push(EV_HALT, 10'd1, 16'd1, 1'b0);
        start_run();
        wait_req("t3_req_seen");
        chk("t3_dmem_we", 32'(dmem_we), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20 && dmem_req; i++) begin
            cnt++;
            if (cnt == 4) dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
        end
        chk("t3_req_cycles", 32'(cnt), 32'd4);
        wait_done("t3_done");

        // T4: store never acked -> timeout after MEM_TO+1 wait cycles
        clear_rom();
        rom[0] = I_STORE;
        push(EV_HALT, 10'd0, 16'd0, 1'b1);
        start_run();
        wait_req("t4_req_seen");
        chk("t4_dmem_we", 32'(dmem_we), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20 && dmem_req; i++) begin
            cnt++;
            tick();
        end
        chk("t4_req_cycles", 32'(cnt), 32'(MEM_TO + 2));
        chk("t4_mem_err", 32'(mem_err), 32'd1);
        chk("t4_done", 32'(done), 32'd1);
        rom[0] = I_HALT;
        push(EV_HALT, 10'd0, 16'd0, 1'b0);
        start_run();
        chk("t4_mem_err_clr", 32'(mem_err), 32'd0);
        wait_done("t4_restart_done");

        // T5: run off the end of the program, with an ignored mid-run start
        clear_rom();
        rom[0] = 9'h079; rom[1] = I_JUMP;
        for (int a = 60; a < 64; a++) rom[a] = I_ADD;
        push(EV_PUT, 10'd0, 16'd0, 1'b0);
        for (int a = 60; a < 64; a++) push(EV_RF, 10'(a), 16'd0, 1'b0);
        push(EV_HALT, 10'd63, 16'd6, 1'b0);
        start_run();
        repeat (5) tick();
        start_run();
        wait_done("t5_done");
        chk("t5_pc_hold", 32'(pc), 32'd63);

        // T5b: async reset during MEM_WAIT drops the request immediately
        clear_rom();
        rom[0] = I_ADD; rom[1] = I_LOAD;
        push(EV_RF, 10'd0, 16'd0, 1'b0);
        start_run();
        wait_req("t5b_req_seen");
        tick(); tick();
        chk("t5b_req_live", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5b_req_drop", 32'(dmem_req), 32'd0);
        chk("t5b_pc", 32'(pc), 32'd0);
        chk("t5b_busy", 32'(busy), 32'd0);
        chk("t5b_retired", 32'(retired), 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();

        chk("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
